// File: rtl/mips_pkg.sv
// Shared multicycle MIPS definitions: datapath width, next-PC select encodings, opcodes.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module flopenr #(
  parameter int unsigned    Width  = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// PC, instruction register and memory data register of the multicycle MIPS datapath,
// plus a retired-fetch counter and sticky fault flags.
module pc_ir_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcwrite,
  input  logic            branch,
  input  logic [1:0]      pcsrc,
  input  logic            irwrite,
  input  logic            iord,
  input  logic            clr_err,
  input  logic            zero,
  input  logic [XLEN-1:0] aluresult,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] readdata,
  output logic [XLEN-1:0] adr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] data,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic [XLEN-1:0] instret,
  output logic            err_misalign,
  output logic            err_pcsrc
);

  logic            pcen;
  logic            pc_load;
  logic [XLEN-1:0] pc_sel;
  logic [XLEN-1:0] pc_d;
  logic            set_misalign;
  logic            set_pcsrc;
  logic            err_misalign_d;
  logic            err_pcsrc_d;
  logic [XLEN-1:0] data_q;

  always_comb begin
    pc_sel = aluresult;
    unique case (pcsrc)
      PCSRC_ALU:    pc_sel = aluresult;
      PCSRC_ALUOUT: pc_sel = aluout;
      PCSRC_JUMP:   pc_sel = {pc[31:28], instr[25:0], 2'b00};
      PCSRC_RSVD:   pc_sel = pc;
      default:      pc_sel = aluresult;
    endcase
  end

  assign pcen    = pcwrite | (branch & zero);
  // The reserved select never updates the PC; it only raises err_pcsrc.
  assign pc_load = pcen && (pcsrc != PCSRC_RSVD);
  assign pc_d    = {pc_sel[XLEN-1:2], 2'b00};

  assign set_misalign = pc_load && (pc_sel[1:0] != 2'b00);
  assign set_pcsrc    = pcen && (pcsrc == PCSRC_RSVD);

  // Set takes priority over a same-cycle clear.
  assign err_misalign_d = set_misalign | (err_misalign & ~clr_err);
  assign err_pcsrc_d    = set_pcsrc | (err_pcsrc & ~clr_err);

  flopenr #(
    .Width    (XLEN),
    .ResetVal (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  flopenr #(
    .Width    (XLEN),
    .ResetVal ('0)
  ) u_ir (
    .clk   (clk),
    .reset (reset),
    .en    (irwrite),
    .d     (readdata),
    .q     (instr)
  );

  flopenr #(
    .Width    (XLEN),
    .ResetVal ('0)
  ) u_instret (
    .clk   (clk),
    .reset (reset),
    .en    (irwrite),
    .d     (instret + 32'd1),
    .q     (instret)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q       <= '0;
      err_misalign <= 1'b0;
      err_pcsrc    <= 1'b0;
    end else begin
      data_q       <= readdata;
      err_misalign <= err_misalign_d;
      err_pcsrc    <= err_pcsrc_d;
    end
  end

  assign data  = data_q;
  assign adr   = iord ? aluout : pc;
  assign op    = instr[31:26];
  assign funct = instr[5:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed self-checking bench for pc_ir_unit.
module tb_pc_ir_unit;

  logic        clk;
  logic        reset;
  logic        pcwrite;
  logic        branch;
  logic [1:0]  pcsrc;
  logic        irwrite;
  logic        iord;
  logic        clr_err;
  logic        zero;
  logic [31:0] aluresult;
  logic [31:0] aluout;
  logic [31:0] readdata;
  logic [31:0] adr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] data;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] instret;
  logic        err_misalign;
  logic        err_pcsrc;

  int unsigned n_tests;
  int unsigned n_fail;

  pc_ir_unit #(
    .RESET_PC (32'h0000_0040)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pcwrite      (pcwrite),
    .branch       (branch),
    .pcsrc        (pcsrc),
    .irwrite      (irwrite),
    .iord         (iord),
    .clr_err      (clr_err),
    .zero         (zero),
    .aluresult    (aluresult),
    .aluout       (aluout),
    .readdata     (readdata),
    .adr          (adr),
    .pc           (pc),
    .instr        (instr),
    .data         (data),
    .op           (op),
    .funct        (funct),
    .instret      (instret),
    .err_misalign (err_misalign),
    .err_pcsrc    (err_pcsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcwrite = 1'b0;
    branch  = 1'b0;
    irwrite = 1'b0;
    clr_err = 1'b0;
    iord    = 1'b0;
    pcsrc   = 2'b00;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    zero      = 1'b0;
    aluresult = '0;
    aluout    = '0;
    readdata  = '0;
    idle();

    // Reset
    #2 reset = 1'b0;
    #10;
    check("rst_pc", pc, 32'h40);
    check("rst_adr", adr, 32'h40);
    check("rst_instr", instr, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_flags", {30'd0, err_misalign, err_pcsrc}, 32'h0);
    step();
    reset = 1'b1;

    // Fetch
    readdata  = 32'h8C01_0004;
    aluresult = 32'h44;
    pcwrite   = 1'b1;
    irwrite   = 1'b1;
    step();
    idle();
    check("fetch_pc", pc, 32'h44);
    check("fetch_instr", instr, 32'h8C01_0004);
    check("fetch_op", {26'd0, op}, 32'h23);
    check("fetch_funct", {26'd0, funct}, 32'h04);
    check("fetch_instret", instret, 32'd1);
    check("fetch_mdr", data, 32'h8C01_0004);

    // Branch qualification
    branch = 1'b1;
    pcsrc  = 2'b01;
    aluout = 32'h100;
    zero   = 1'b0;
    step();
    check("br_nottaken", pc, 32'h44);
    zero = 1'b1;
    step();
    check("br_taken", pc, 32'h100);
    idle();
    zero = 1'b0;

    // Jump
    aluresult = 32'h3000_0000;
    readdata  = 32'h0800_0010;
    pcwrite   = 1'b1;
    irwrite   = 1'b1;
    step();
    check("jsetup_pc", pc, 32'h3000_0000);
    check("jsetup_instret", instret, 32'd2);
    irwrite = 1'b0;
    pcsrc   = 2'b10;
    step();
    check("jump_pc", pc, 32'h3000_0040);

    // Misalign and sticky clear
    pcsrc     = 2'b00;
    aluresult = 32'h42;
    step();
    check("mis_pc", pc, 32'h40);
    check("mis_flag", {31'd0, err_misalign}, 32'd1);
    pcwrite = 1'b0;
    step();
    check("mis_sticky", {31'd0, err_misalign}, 32'd1);
    clr_err = 1'b1;
    step();
    check("mis_clear", {31'd0, err_misalign}, 32'd0);
    pcwrite   = 1'b1;
    aluresult = 32'h43;
    step();
    check("mis_setwins", {31'd0, err_misalign}, 32'd1);
    check("mis_setwins_pc", pc, 32'h40);
    pcwrite = 1'b0;
    step();
    check("mis_clear2", {31'd0, err_misalign}, 32'd0);
    idle();

    // Reserved select
    pcwrite   = 1'b1;
    pcsrc     = 2'b11;
    aluresult = 32'h80;
    step();
    idle();
    check("rsvd_pc", pc, 32'h40);
    check("rsvd_flag", {31'd0, err_pcsrc}, 32'd1);
    check("rsvd_nomis", {31'd0, err_misalign}, 32'd0);

    // iord and MDR
    iord   = 1'b1;
    aluout = 32'h200;
    #1;
    check("iord_adr", adr, 32'h200);
    readdata = 32'hDEAD_BEEF;
    step();
    check("mdr", data, 32'hDEAD_BEEF);
    check("ir_hold", instr, 32'h0800_0010);
    iord = 1'b0;
    #1;
    check("pc_adr", adr, 32'h40);

    // Async reset mid-cycle
    pcwrite   = 1'b1;
    irwrite   = 1'b1;
    aluresult = 32'h500;
    step();
    idle();
    check("pre_rst_pc", pc, 32'h500);
    #2 reset = 1'b0;
    #1;
    check("arst_pc", pc, 32'h40);
    check("arst_instr", instr, 32'h0);
    check("arst_instret", instret, 32'h0);
    check("arst_data", data, 32'h0);
    check("arst_flags", {30'd0, err_misalign, err_pcsrc}, 32'h0);
    step();
    reset = 1'b1;

    // instret wrap
    force dut.u_instret.q = 32'hFFFF_FFFF;
    #1;
    release dut.u_instret.q;
    #1;
    check("pre_wrap", instret, 32'hFFFF_FFFF);
    irwrite  = 1'b1;
    readdata = 32'h0000_0000;
    step();
    idle();
    check("wrap", instret, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Program-counter and instruction-capture stage of the multicycle MIPS datapath, directly downstream of the main control decoder. It consumes the decoder's pcwrite, branch, pcsrc, irwrite and iord controls together with ALU results, and owns the PC, instruction register (IR) and memory data register (MDR). It drives the unified memory address and returns the opcode/funct fields the decoders consume. It also keeps a retired-fetch counter and sticky fault flags for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- pcwrite  in  1  unconditional PC write enable from decoder
- branch  in  1  conditional PC write enable, qualified by zero
- pcsrc  in  2  next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 reserved
- irwrite  in  1  IR load enable
- iord  in  1  address select: 0 PC, 1 aluout
- clr_err  in  1  synchronous clear of sticky fault flags
- zero  in  1  ALU zero flag (current cycle)
- aluresult  in  32  combinational ALU output
- aluout  in  32  registered ALU output
- readdata  in  32  memory read data (combinational w.r.t. adr)
- adr  out  32  memory address
- pc  out  32  current PC
- instr  out  32  IR contents
- data  out  32  MDR contents
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- instret  out  32  count of IR loads, wraps
- err_misalign  out  1  sticky: a PC write carried nonzero low bits
- err_pcsrc  out  1  sticky: PC write attempted with pcsrc=11

## Operation
- pcen = pcwrite | (branch & zero).
- Jump target = {pc[31:28], instr[25:0], 2'b00}.
- PC write on edge when pcen and pcsrc≠11: PC ← selected value with bits [1:0] forced to 00; if selected value[1:0]≠00, set err_misalign.
- pcen with pcsrc=11: PC holds, err_pcsrc set.
- adr = iord ? aluout : pc (combinational, no latency).
- IR ← readdata on edge when irwrite; otherwise holds.
- MDR ← readdata every edge (non-architectural, unconditional).
- instret increments by 1 on each edge with irwrite; 32'hFFFF_FFFF wraps to 0.
- Sticky flags: set on event, cleared by clr_err. Same-cycle set and clr_err → set wins.
- op/funct: pure slices of IR, change only when IR loads.

## Timing
- Reset (reset=0, async): pc=RESET_PC, instr=0, data=0, instret=0, err_misalign=0, err_pcsrc=0; adr=RESET_PC when iord=0.
- First rising edge after reset deasserts: normal operation, no extra wait cycle.
- Fetch cycle (pcwrite=1, irwrite=1, iord=0, pcsrc=00): IR captures readdata at old PC. PC becomes aluresult (PC+4) on the same edge. Both are visible the next cycle.
- Branch: zero sampled in the branch cycle; PC updated at end of that cycle.
- Reset asserted mid-instruction: all state returns immediately to reset values regardless of clk. Controls in flight are ignored.
- No handshakes; memory is single-cycle combinational read.

## Structure
- Shared package mips_pkg: PCSRC_ALU/PCSRC_ALUOUT/PCSRC_JUMP/PCSRC_RSVD encodings, opcode constants (LW, SW, RTYPE, BEQ, ADDI, J), XLEN=32.
- The same package is imported by the main decoder.
- One sub-module: flopenr (parameterised width, async active-low reset, enable, reset value). Instantiated for PC, IR and instret.
- MDR and flags use plain always_ff.

## Test plan
- Reset check: RESET_PC=32'h0000_0040, hold reset=0 → pc=0x40, adr=0x40, instr=0, instret=0, flags 0.
- Fetch: readdata=0x8C01_0004, aluresult=0x44, pcwrite=irwrite=1 for one edge → pc=0x44, instr=0x8C01_0004, op=6'b100011, instret=1.
- Branch qualification: branch=1, pcsrc=01, aluout=0x100 with zero=0 → pc unchanged. Same with zero=1 → pc=0x100.
- Jump and misalign: pc=0x3000_0000, instr=0x0800_0010, pcsrc=10, pcwrite=1 → pc=0x3000_0040. Then pcsrc=00, aluresult=0x42 → pc=0x40, err_misalign=1, cleared by clr_err next edge.
- Reserved select and iord: pcwrite=1, pcsrc=11 → pc holds, err_pcsrc=1. iord=1, aluout=0x200 → adr=0x200, and MDR equals readdata after the edge.
- Async reset mid-run and wrap: drive reset=0 between edges → outputs reset without a clock edge. Preload instret=0xFFFF_FFFF via 2^32-1 loads (or force), one more irwrite → instret=0.
